// File: rtl/rc4_key_search_sequencer.sv
// rc4_key_search_sequencer: steps candidate keys through S-init, KSA shuffle and
// PRGA decrypt/check, owning and multiplexing the single-port S memory.
module rc4_key_search_sequencer #(
    parameter int KEY_WIDTH      = 24,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TO_WIDTH       = 13
) (
    input  logic                 CLOCK_50,
    input  logic                 reset_n,
    input  logic                 go,
    input  logic                 abort,
    input  logic [KEY_WIDTH-1:0] key_start,
    input  logic [KEY_WIDTH-1:0] key_end,
    output logic                 init_start,
    output logic                 shuf_start,
    output logic                 dec_start,
    input  logic                 init_done,
    input  logic                 shuf_done,
    input  logic                 dec_done,
    input  logic                 dec_key_ok,
    input  logic [7:0]           init_addr,
    input  logic [7:0]           shuf_addr,
    input  logic [7:0]           dec_addr,
    input  logic [7:0]           init_data,
    input  logic [7:0]           shuf_data,
    input  logic [7:0]           dec_data,
    input  logic                 init_wren,
    input  logic                 shuf_wren,
    input  logic                 dec_wren,
    output logic [7:0]           s_addr,
    output logic [7:0]           s_data,
    output logic                 s_wren,
    output logic [KEY_WIDTH-1:0] cur_key,
    output logic                 busy,
    output logic                 found,
    output logic                 exhausted,
    output logic                 error,
    output logic [1:0]           phase
);
    typedef enum logic [3:0] {
        IDLE, LOAD, INIT_GO, INIT_WAIT, SHUF_GO, SHUF_WAIT,
        DEC_GO, DEC_WAIT, CHECK, FOUND, EXHAUSTED, ERROR
    } state_t;

    state_t               state, state_nx;
    logic [KEY_WIDTH-1:0] end_reg;
    logic [TO_WIDTH-1:0]  wd;
    logic                 ok_reg;
    logic                 timeout;

    // wd counts WAIT cycles from 0, so expiry lands TIMEOUT_CYCLES cycles after the start pulse
    assign timeout = wd == TO_WIDTH'(TIMEOUT_CYCLES - 2);

    always_ff @(posedge CLOCK_50 or negedge reset_n)
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nx;

    always_ff @(posedge CLOCK_50 or negedge reset_n)
        if (!reset_n) begin
            cur_key <= '0;
            end_reg <= '0;
            wd      <= '0;
            ok_reg  <= 1'b0;
        end else if (!abort) begin
            case (state)
                LOAD: begin
                    cur_key <= key_start;
                    end_reg <= key_end;
                end
                INIT_GO, SHUF_GO, DEC_GO:       wd <= '0;
                INIT_WAIT, SHUF_WAIT, DEC_WAIT: wd <= wd + TO_WIDTH'(1);
                CHECK: if (!ok_reg && cur_key != end_reg) cur_key <= cur_key + KEY_WIDTH'(1);
                default: ;
            endcase
            if (state == DEC_WAIT && dec_done) ok_reg <= dec_key_ok;
        end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, FOUND, EXHAUSTED, ERROR: state_nx = go ? LOAD : state;
            LOAD:      state_nx = key_start > key_end ? EXHAUSTED : INIT_GO;
            INIT_GO:   state_nx = INIT_WAIT;
            INIT_WAIT: state_nx = init_done ? SHUF_GO : timeout ? ERROR : INIT_WAIT;
            SHUF_GO:   state_nx = SHUF_WAIT;
            SHUF_WAIT: state_nx = shuf_done ? DEC_GO : timeout ? ERROR : SHUF_WAIT;
            DEC_GO:    state_nx = DEC_WAIT;
            DEC_WAIT:  state_nx = dec_done ? CHECK : timeout ? ERROR : DEC_WAIT;
            CHECK:     state_nx = ok_reg ? FOUND : cur_key == end_reg ? EXHAUSTED : INIT_GO;
            default:   state_nx = IDLE;
        endcase
        if (abort) state_nx = IDLE;
    end

    always_comb begin
        phase      = (state == INIT_GO || state == INIT_WAIT) ? 2'd1 :
                     (state == SHUF_GO || state == SHUF_WAIT) ? 2'd2 :
                     (state == DEC_GO  || state == DEC_WAIT)  ? 2'd3 : 2'd0;
        s_addr     = phase == 2'd1 ? init_addr : phase == 2'd2 ? shuf_addr : phase == 2'd3 ? dec_addr : 8'h00;
        s_data     = phase == 2'd1 ? init_data : phase == 2'd2 ? shuf_data : phase == 2'd3 ? dec_data : 8'h00;
        s_wren     = !abort && (phase == 2'd1 ? init_wren : phase == 2'd2 ? shuf_wren : phase == 2'd3 && dec_wren);
        init_start = !abort && state == INIT_GO;
        shuf_start = !abort && state == SHUF_GO;
        dec_start  = !abort && state == DEC_GO;
        busy       = !(state inside {IDLE, FOUND, EXHAUSTED, ERROR});
        found      = state == FOUND;
        exhausted  = state == EXHAUSTED;
        error      = state == ERROR;
    end
endmodule

// File: tb/tb_rc4_key_search_sequencer.sv
// tb_rc4_key_search_sequencer: emulated phase engines, a phase-ownership/watchdog
// model checked every cycle, and directed key-search scenarios.
module tb_rc4_key_search_sequencer;
    localparam int KW = 24;
    localparam int T  = 4096;

    logic          CLOCK_50 = 0, reset_n = 0, go = 0, abort = 0;
    logic [KW-1:0] key_start = 0, key_end = 0;
    logic          init_done = 0, shuf_done = 0, dec_done = 0, dec_key_ok = 0;
    logic [7:0]    init_addr = 0, shuf_addr = 0, dec_addr = 0;
    logic [7:0]    init_data = 0, shuf_data = 0, dec_data = 0;
    logic          init_wren = 0, shuf_wren = 0, dec_wren = 0;
    logic          init_start, shuf_start, dec_start;
    logic [7:0]    s_addr, s_data;
    logic          s_wren, busy, found, exhausted, error;
    logic [KW-1:0] cur_key;
    logic [1:0]    phase;

    rc4_key_search_sequencer #(.KEY_WIDTH(KW), .TIMEOUT_CYCLES(T), .TO_WIDTH(13)) dut (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .go(go), .abort(abort),
        .key_start(key_start), .key_end(key_end),
        .init_start(init_start), .shuf_start(shuf_start), .dec_start(dec_start),
        .init_done(init_done), .shuf_done(shuf_done), .dec_done(dec_done), .dec_key_ok(dec_key_ok),
        .init_addr(init_addr), .shuf_addr(shuf_addr), .dec_addr(dec_addr),
        .init_data(init_data), .shuf_data(shuf_data), .dec_data(dec_data),
        .init_wren(init_wren), .shuf_wren(shuf_wren), .dec_wren(dec_wren),
        .s_addr(s_addr), .s_data(s_data), .s_wren(s_wren), .cur_key(cur_key),
        .busy(busy), .found(found), .exhausted(exhausted), .error(error), .phase(phase)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int            total = 0, bad = 0, cyc = 0;
    int            lat[4];
    int            n_start[4];
    int            m_next = 1;
    logic [KW-1:0] m_key = 0, ok_key = 0;
    bit            force_dwren = 0;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // Phase engines: done arrives lat[x] cycles after start (lat 0 = never), randomised S requests
    initial begin
        int   cnt[4];
        logic dn[4];
        forever begin
            @(posedge CLOCK_50);
            #1;
            for (int x = 1; x < 4; x++) begin
                dn[x] = 0;
                if (!reset_n || abort) cnt[x] = 0;
                else if (cnt[x] > 0) begin
                    cnt[x]--;
                    dn[x] = cnt[x] == 0;
                end
            end
            if (init_start && lat[1] > 0) cnt[1] = lat[1];
            if (shuf_start && lat[2] > 0) cnt[2] = lat[2];
            if (dec_start  && lat[3] > 0) cnt[3] = lat[3];
            init_done  = dn[1];
            shuf_done  = dn[2];
            dec_done   = dn[3];
            dec_key_ok = dn[3] && cur_key == ok_key;
            {init_addr, init_data, shuf_addr, shuf_data} = $urandom;
            {dec_addr, dec_data} = 16'($urandom);
            init_wren = 1'($urandom_range(0, 1));
            shuf_wren = 1'($urandom_range(0, 1));
            dec_wren  = force_dwren ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    // Model: the phase owner is whoever last pulsed start, until its done, abort or T cycles elapse
    initial begin
        int         owner, age, x;
        bit         pc;
        logic [2:0] sv;
        owner = 0; age = 0; pc = 0;
        forever begin
            @(negedge CLOCK_50);
            if (!reset_n) begin
                owner = 0; pc = 0;
                chk("rst_flags", {busy, found, exhausted, error, phase, s_wren, init_start, shuf_start, dec_start}, 0);
                chk("rst_s", {s_addr, s_data}, 0);
                chk("rst_key", cur_key, 0);
            end else begin
                if (pc) owner = 0;
                sv = {dec_start, shuf_start, init_start};
                chk("start_onehot", $onehot0(sv) && !(abort && sv != 0), 1);
                if (sv != 0) begin
                    x = sv[0] ? 1 : sv[1] ? 2 : 3;
                    chk("start_order", x, m_next);
                    m_next = x % 3 + 1;
                    if (x == 1) begin
                        chk("start_key", cur_key, m_key);
                        m_key++;
                    end
                    n_start[x]++;
                    owner = x;
                    age = 0;
                end else if (owner != 0) age++;
                if (owner != 0 && age == T) begin
                    chk("wd_error", error, 1);
                    owner = 0;
                end else if (owner != 0) chk("wd_early", error, 0);
                chk("phase", phase, owner);
                chk("s_addr", s_addr, owner == 1 ? init_addr : owner == 2 ? shuf_addr : owner == 3 ? dec_addr : 8'h00);
                chk("s_data", s_data, owner == 1 ? init_data : owner == 2 ? shuf_data : owner == 3 ? dec_data : 8'h00);
                chk("s_wren", s_wren, !abort && (owner == 1 ? init_wren : owner == 2 ? shuf_wren : owner == 3 && dec_wren));
                pc = abort || (owner == 1 && init_done) || (owner == 2 && shuf_done) || (owner == 3 && dec_done);
            end
        end
    end

    task automatic launch(input logic [KW-1:0] ks, input logic [KW-1:0] ke, input logic [KW-1:0] ok,
                          input int li, input int ls, input int ld, output int t0);
        @(posedge CLOCK_50);
        #2;
        key_start = ks; key_end = ke; ok_key = ok;
        lat[1] = li; lat[2] = ls; lat[3] = ld;
        m_key = ks; m_next = 1;
        n_start = '{default: 0};
        go = 1;
        t0 = cyc;
        @(posedge CLOCK_50);
        #2;
        go = 0;
    endtask

    task automatic run(input logic [KW-1:0] ks, input logic [KW-1:0] ke, input logic [KW-1:0] ok,
                       input int li, input int ls, input int ld, output int dt);
        int t0;
        launch(ks, ke, ok, li, ls, ld, t0);
        dt = -1;
        for (int i = 0; i < 6000; i++) begin
            @(negedge CLOCK_50);
            if (found || exhausted || error) begin
                dt = cyc - t0;
                break;
            end
        end
        if (dt < 0) chk("end_within_budget", found || exhausted || error, 1);
    endtask

    task automatic wait_start(input int x);
        for (int i = 0; i < 200; i++) begin
            @(negedge CLOCK_50);
            if ((x == 2 && shuf_start) || (x == 3 && dec_start)) return;
        end
        chk("start_within_budget", 0, 1);
    endtask

    initial begin
        int dt, t0;
        repeat (3) @(posedge CLOCK_50);
        #2;
        reset_n = 1;
        chk("idle_busy", busy, 0);
        chk("idle_key", cur_key, 0);

        run(24'h000249, 24'h000249, 24'h000249, 3, 3, 3, dt);
        chk("basic_found", found, 1);
        chk("basic_key", cur_key, 24'h000249);
        chk("basic_busy", busy, 0);
        chk("basic_latency", dt, 15);
        chk("basic_starts", {n_start[1][3:0], n_start[2][3:0], n_start[3][3:0]}, 12'h111);

        run(0, 3, 2, 1, 2, 1, dt);
        chk("sweep_found", found, 1);
        chk("sweep_key", cur_key, 2);
        chk("sweep_inits", n_start[1], 3);

        run(5, 7, 24'hFFFFFF, 2, 1, 3, dt);
        chk("exh_flag", exhausted, 1);
        chk("exh_found", found, 0);
        chk("exh_key", cur_key, 7);
        chk("exh_inits", n_start[1], 3);

        run(8, 3, 24'hFFFFFF, 1, 1, 1, dt);
        chk("rev_flag", exhausted, 1);
        chk("rev_inits", n_start[1], 0);
        chk("rev_key", cur_key, 8);
        chk("rev_latency", dt, 2);

        run(24'h000040, 24'h000050, 24'hFFFFFF, 3, 0, 3, dt);
        chk("wd_flag", error, 1);
        chk("wd_latency", dt, 6 + T);
        chk("wd_busy", busy, 0);
        run(24'h000249, 24'h000249, 24'h000249, 3, 3, 3, dt);
        chk("wd_restart_found", found, 1);
        chk("wd_restart_key", cur_key, 24'h000249);

        launch(24'h000010, 24'h000010, 24'h000010, 2, 2, 0, t0);
        wait_start(3);
        force_dwren = 1;
        repeat (2) @(posedge CLOCK_50);
        #2;
        abort = 1;
        #1;
        chk("abort_wren", s_wren, 0);
        chk("abort_busy", busy, 1);
        @(posedge CLOCK_50);
        #2;
        abort = 0;
        force_dwren = 0;
        chk("abort_idle_busy", busy, 0);
        chk("abort_phase", phase, 0);
        chk("abort_key", cur_key, 24'h000010);

        @(posedge CLOCK_50);
        #2;
        go = 1; abort = 1;
        @(posedge CLOCK_50);
        #2;
        go = 0; abort = 0;
        chk("go_abort_busy", busy, 0);

        launch(24'h000020, 24'h000030, 24'hFFFFFF, 2, 0, 2, t0);
        wait_start(2);
        repeat (5) @(posedge CLOCK_50);
        #3;
        chk("pre_reset_phase", phase, 2);
        reset_n = 0;
        #1;
        chk("rst_async_busy", busy, 0);
        chk("rst_async_phase", phase, 0);
        chk("rst_async_s", {s_addr, s_data, 7'd0, s_wren}, 0);
        chk("rst_async_key", cur_key, 0);
        @(posedge CLOCK_50);
        #2;
        reset_n = 1;
        run(24'h000249, 24'h000249, 24'h000249, 3, 3, 3, dt);
        chk("rst_restart_found", found, 1);
        chk("rst_restart_latency", dt, 15);

        repeat (2) @(posedge CLOCK_50);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
